// File: rtl/operand_hazard_controller.sv
// Execute-stage operand controller.
// Tracks the destination registers of the instructions in EX and MEM. Computes the ALU
// input-1 select and the forwarding selects for both operands, registered into EX.
// A small FSM turns load-use hazards into one stall bubble and taken branches into
// FLUSH_CYCLES flush bubbles.
module operand_hazard_controller #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned REG_ADDR_W   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  idValid,
   input  logic [REG_ADDR_W-1:0] idRs1,
   input  logic [REG_ADDR_W-1:0] idRs2,
   input  logic                  idUsesRs1,
   input  logic                  idUsesRs2,
   input  logic [1:0]            idOp1Kind,
   input  logic [REG_ADDR_W-1:0] idRd,
   input  logic                  idRegWrite,
   input  logic                  idMemRead,
   input  logic                  branchTaken,
   input  logic                  stallExternal,
   output logic [1:0]            input1Select,
   output logic [1:0]            fwd1Select,
   output logic [1:0]            fwd2Select,
   output logic                  exValid,
   output logic                  stallId,
   output logic                  flushIfId
);

   typedef enum logic [1:0] {
      StRun,
      StLoadStall,
      StFlush
   } state_e;

   localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

   localparam logic [1:0] SelReg  = 2'b00;
   localparam logic [1:0] SelPc   = 2'b01;
   localparam logic [1:0] SelZero = 2'b10;

   localparam logic [1:0] FwdRegFile = 2'b00;
   localparam logic [1:0] FwdExMem   = 2'b01;
   localparam logic [1:0] FwdMemWb   = 2'b10;

   state_e     state_q, state_d;
   logic [1:0] flush_count_q, flush_count_d;

   // EX and MEM stage slots. No WB slot is kept: once an ID instruction reaches EX,
   // the instruction now in MEM/WB has already written the register file.
   logic                  ex_valid_q;
   logic [REG_ADDR_W-1:0] ex_rd_q;
   logic                  ex_regwrite_q;
   logic                  ex_memread_q;
   logic                  mem_valid_q;
   logic [REG_ADDR_W-1:0] mem_rd_q;
   logic                  mem_regwrite_q;

   logic [1:0] input1_sel_q, fwd1_sel_q, fwd2_sel_q;

   logic       ex_fwd_ok, mem_fwd_ok;
   logic [1:0] fwd1_d, fwd2_d, op1_sel_d;
   logic       load_use;
   logic       take_id;

   // Which in-flight stages may forward at all (x0 is never forwarded).
   always_comb begin
      ex_fwd_ok  = ex_valid_q & ex_regwrite_q & (ex_rd_q != '0);
      mem_fwd_ok = mem_valid_q & mem_regwrite_q & (mem_rd_q != '0);
   end

   // Forward selects seen from ID: current EX becomes EX/MEM, current MEM becomes MEM/WB.
   always_comb begin
      fwd1_d = FwdRegFile;
      if (idUsesRs1 && ex_fwd_ok && (ex_rd_q == idRs1)) begin
         fwd1_d = FwdExMem;
      end else if (idUsesRs1 && mem_fwd_ok && (mem_rd_q == idRs1)) begin
         fwd1_d = FwdMemWb;
      end
      fwd2_d = FwdRegFile;
      if (idUsesRs2 && ex_fwd_ok && (ex_rd_q == idRs2)) begin
         fwd2_d = FwdExMem;
      end else if (idUsesRs2 && mem_fwd_ok && (mem_rd_q == idRs2)) begin
         fwd2_d = FwdMemWb;
      end
   end

   // Operand-1 source decode; the reserved code falls back to the register path.
   always_comb begin
      case (idOp1Kind)
         2'b01:   op1_sel_d = SelPc;
         2'b10:   op1_sel_d = SelZero;
         default: op1_sel_d = SelReg;
      endcase
   end

   // A load in EX whose rd is read by the ID instruction cannot be forwarded in time.
   always_comb begin
      load_use = idValid & ex_valid_q & ex_memread_q & (ex_rd_q != '0) &
                 ((idUsesRs1 & (idRs1 == ex_rd_q)) | (idUsesRs2 & (idRs2 == ex_rd_q)));
   end

   // Next-state decision: stall/flush strobes and whether ID or a bubble enters EX.
   always_comb begin
      state_d       = state_q;
      flush_count_d = flush_count_q;
      take_id       = 1'b0;
      stallId       = 1'b0;
      flushIfId     = 1'b0;
      if (stallExternal) begin
         stallId = 1'b1;
      end else begin
         case (state_q)
            StRun, StLoadStall: begin
               if (branchTaken) begin
                  flushIfId = 1'b1;
                  if (FlushInit != 2'd0) begin
                     state_d       = StFlush;
                     flush_count_d = FlushInit;
                  end else begin
                     state_d       = StRun;
                     flush_count_d = 2'd0;
                  end
               end else if ((state_q == StRun) && load_use) begin
                  stallId = 1'b1;
                  state_d = StLoadStall;
               end else begin
                  // In LOAD_STALL the held instruction enters; the load now sits in MEM.
                  take_id = 1'b1;
                  state_d = StRun;
               end
            end
            StFlush: begin
               // EX holds a bubble here, so any branchTaken is spurious and ignored.
               flushIfId     = 1'b1;
               flush_count_d = flush_count_q - 2'd1;
               if (flush_count_q <= 2'd1) begin
                  state_d       = StRun;
                  flush_count_d = 2'd0;
               end
            end
            default: begin
               state_d       = StRun;
               flush_count_d = 2'd0;
            end
         endcase
      end
   end

   // Pipeline advance: FSM, stage slots and registered selects; all hold on stallExternal.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StRun;
         flush_count_q  <= 2'd0;
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         mem_valid_q    <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         input1_sel_q   <= SelReg;
         fwd1_sel_q     <= FwdRegFile;
         fwd2_sel_q     <= FwdRegFile;
      end else if (!stallExternal) begin
         state_q        <= state_d;
         flush_count_q  <= flush_count_d;
         mem_valid_q    <= ex_valid_q;
         mem_rd_q       <= ex_rd_q;
         mem_regwrite_q <= ex_regwrite_q;
         if (take_id) begin
            ex_valid_q    <= idValid;
            ex_rd_q       <= idRd;
            ex_regwrite_q <= idRegWrite;
            ex_memread_q  <= idMemRead;
            input1_sel_q  <= op1_sel_d;
            fwd1_sel_q    <= fwd1_d;
            fwd2_sel_q    <= fwd2_d;
         end else begin
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            input1_sel_q  <= SelReg;
            fwd1_sel_q    <= FwdRegFile;
            fwd2_sel_q    <= FwdRegFile;
         end
      end
   end

   assign input1Select = input1_sel_q;
   assign fwd1Select   = fwd1_sel_q;
   assign fwd2Select   = fwd2_sel_q;
   assign exValid      = ex_valid_q;

endmodule

// File: tb/tb_operand_hazard_controller.sv
// Directed bench for operand_hazard_controller (FLUSH_CYCLES = 2).
module tb_operand_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       idValid;
   logic [4:0] idRs1, idRs2, idRd;
   logic       idUsesRs1, idUsesRs2;
   logic [1:0] idOp1Kind;
   logic       idRegWrite, idMemRead;
   logic       branchTaken, stallExternal;
   logic [1:0] input1Select, fwd1Select, fwd2Select;
   logic       exValid, stallId, flushIfId;

   int checks = 0;
   int errors = 0;

   operand_hazard_controller #(
      .FLUSH_CYCLES(2),
      .REG_ADDR_W  (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .idValid      (idValid),
      .idRs1        (idRs1),
      .idRs2        (idRs2),
      .idUsesRs1    (idUsesRs1),
      .idUsesRs2    (idUsesRs2),
      .idOp1Kind    (idOp1Kind),
      .idRd         (idRd),
      .idRegWrite   (idRegWrite),
      .idMemRead    (idMemRead),
      .branchTaken  (branchTaken),
      .stallExternal(stallExternal),
      .input1Select (input1Select),
      .fwd1Select   (fwd1Select),
      .fwd2Select   (fwd2Select),
      .exValid      (exValid),
      .stallId      (stallId),
      .flushIfId    (flushIfId)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [1:0] kind, input logic [4:0] rd,
                         input logic rw, input logic mr);
      idValid    = 1'b1;
      idRs1      = rs1;
      idRs2      = rs2;
      idUsesRs1  = u1;
      idUsesRs2  = u2;
      idOp1Kind  = kind;
      idRd       = rd;
      idRegWrite = rw;
      idMemRead  = mr;
      #1;
   endtask

   task automatic nop();
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      branchTaken = 1'b0;
      stallExternal = 1'b0;
      nop();
      step();
      check("rst_exvalid", {7'd0, exValid}, 8'd0);
      check("rst_in1", {6'd0, input1Select}, 8'd0);
      check("rst_fwd1", {6'd0, fwd1Select}, 8'd0);
      check("rst_fwd2", {6'd0, fwd2Select}, 8'd0);
      reset = 1'b0;

      // EX->EX forwarding: ADD x5 then SUB x6,x5,x5.
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd5, 1'b1, 1'b0);
      check("add_nostall", {7'd0, stallId}, 8'd0);
      step();
      check("add_exvalid", {7'd0, exValid}, 8'd1);
      set_id(5'd5, 5'd5, 1'b1, 1'b1, 2'b00, 5'd6, 1'b1, 1'b0);
      step();
      check("exfwd_fwd1", {6'd0, fwd1Select}, 8'h01);
      check("exfwd_fwd2", {6'd0, fwd2Select}, 8'h01);
      check("exfwd_in1", {6'd0, input1Select}, 8'h00);

      // MEM forwarding with one unrelated instruction in between.
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd8, 1'b1, 1'b0);
      step();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd9, 1'b1, 1'b0);
      step();
      set_id(5'd8, 5'd8, 1'b1, 1'b1, 2'b00, 5'd6, 1'b1, 1'b0);
      step();
      check("memfwd_fwd1", {6'd0, fwd1Select}, 8'h02);
      check("memfwd_fwd2", {6'd0, fwd2Select}, 8'h02);

      // x0 is never forwarded.
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd0, 1'b1, 1'b0);
      step();
      set_id(5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 5'd6, 1'b1, 1'b0);
      step();
      check("x0_fwd1", {6'd0, fwd1Select}, 8'h00);
      check("x0_fwd2", {6'd0, fwd2Select}, 8'h00);
      check("x0_exvalid", {7'd0, exValid}, 8'd1);

      // Load-use: LW x7 then ADD x10,x3,x7.
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 2'b00, 5'd7, 1'b1, 1'b1);
      step();
      set_id(5'd3, 5'd7, 1'b1, 1'b1, 2'b00, 5'd10, 1'b1, 1'b0);
      check("lu_stall", {7'd0, stallId}, 8'd1);
      check("lu_noflush", {7'd0, flushIfId}, 8'd0);
      step();
      check("lu_bubble", {7'd0, exValid}, 8'd0);
      check("lu_release", {7'd0, stallId}, 8'd0);
      step();
      check("lu_exvalid", {7'd0, exValid}, 8'd1);
      check("lu_fwd1", {6'd0, fwd1Select}, 8'h00);
      check("lu_fwd2", {6'd0, fwd2Select}, 8'h02);

      // Operand-1 source kinds: AUIPC, LUI, reserved.
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 5'd11, 1'b1, 1'b0);
      step();
      check("auipc_in1", {6'd0, input1Select}, 8'h01);
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 5'd12, 1'b1, 1'b0);
      step();
      check("lui_in1", {6'd0, input1Select}, 8'h02);
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 2'b11, 5'd12, 1'b1, 1'b0);
      step();
      check("rsvd_in1", {6'd0, input1Select}, 8'h00);

      // Taken branch: two flush/bubble cycles, then normal flow.
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 5'd13, 1'b1, 1'b0);
      branchTaken = 1'b1;
      #1;
      check("br_flush0", {7'd0, flushIfId}, 8'd1);
      check("br_nostall", {7'd0, stallId}, 8'd0);
      step();
      branchTaken = 1'b0;
      #1;
      check("br_bubble0", {7'd0, exValid}, 8'd0);
      check("br_flush1", {7'd0, flushIfId}, 8'd1);
      step();
      check("br_bubble1", {7'd0, exValid}, 8'd0);
      check("br_flush_done", {7'd0, flushIfId}, 8'd0);
      step();
      check("br_resume", {7'd0, exValid}, 8'd1);
      check("br_resume_in1", {6'd0, input1Select}, 8'h01);

      // Branch during LOAD_STALL: flush wins.
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd7, 1'b1, 1'b1);
      step();
      set_id(5'd3, 5'd7, 1'b1, 1'b1, 2'b00, 5'd10, 1'b1, 1'b0);
      check("lsbr_stall", {7'd0, stallId}, 8'd1);
      step();
      branchTaken = 1'b1;
      #1;
      check("lsbr_flush", {7'd0, flushIfId}, 8'd1);
      check("lsbr_nostall", {7'd0, stallId}, 8'd0);
      step();
      branchTaken = 1'b0;
      nop();
      check("lsbr_bubble", {7'd0, exValid}, 8'd0);
      check("lsbr_flush1", {7'd0, flushIfId}, 8'd1);
      step();
      check("lsbr_done", {7'd0, flushIfId}, 8'd0);

      // External stall held 3 cycles with a load-use pending.
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd14, 1'b1, 1'b0);
      step();
      set_id(5'd14, 5'd0, 1'b1, 1'b0, 2'b00, 5'd7, 1'b1, 1'b1);
      step();
      check("ext_lw_fwd1", {6'd0, fwd1Select}, 8'h01);
      set_id(5'd3, 5'd7, 1'b1, 1'b1, 2'b00, 5'd15, 1'b1, 1'b0);
      stallExternal = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("ext_stallid", {7'd0, stallId}, 8'd1);
         check("ext_noflush", {7'd0, flushIfId}, 8'd0);
         step();
         check("ext_exvalid", {7'd0, exValid}, 8'd1);
         check("ext_fwd1", {6'd0, fwd1Select}, 8'h01);
      end
      stallExternal = 1'b0;
      #1;
      check("ext_lu_stall", {7'd0, stallId}, 8'd1);
      step();
      check("ext_bubble", {7'd0, exValid}, 8'd0);
      check("ext_bubble_fwd1", {6'd0, fwd1Select}, 8'h00);
      check("ext_release", {7'd0, stallId}, 8'd0);
      step();
      check("ext_add_valid", {7'd0, exValid}, 8'd1);
      check("ext_add_fwd2", {6'd0, fwd2Select}, 8'h02);

      // Asynchronous reset mid-stream.
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd16, 1'b1, 1'b0);
      step();
      set_id(5'd16, 5'd0, 1'b1, 1'b0, 2'b00, 5'd17, 1'b1, 1'b0);
      step();
      check("pre_rst_fwd1", {6'd0, fwd1Select}, 8'h01);
      check("pre_rst_valid", {7'd0, exValid}, 8'd1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", {7'd0, exValid}, 8'd0);
      check("arst_fwd1", {6'd0, fwd1Select}, 8'h00);
      check("arst_in1", {6'd0, input1Select}, 8'h00);
      #1;
      reset = 1'b0;
      // Slots were cleared: x16 is no longer forwardable, FSM is in RUN.
      set_id(5'd16, 5'd16, 1'b1, 1'b1, 2'b00, 5'd18, 1'b1, 1'b0);
      check("arst_run_nostall", {7'd0, stallId}, 8'd0);
      step();
      check("arst_run_valid", {7'd0, exValid}, 8'd1);
      check("arst_run_fwd1", {6'd0, fwd1Select}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
